// File: rtl/sync_fifo_v2.sv
// sync_fifo_v2: single-clock FIFO with standard/FWFT read, occupancy flags, error pulses and high-water mark
module sync_fifo_v2 #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int FWFT  = 0,
  parameter int CW    = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  input  logic [CW-1:0]    af_thresh,
  input  logic [CW-1:0]    ae_thresh,
  input  logic             max_clr,
  output logic             is_full,
  output logic             almost_full,
  output logic             is_empty,
  output logic             almost_empty,
  output logic             overflow,
  output logic             underflow,
  output logic [CW-1:0]    level,
  output logic [CW-1:0]    max_level
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]    r_level, r_max, w_next;
  logic             r_ovf, r_unf, w_push_acc, w_pop_acc;
  assign w_pop_acc    = pop & ~flush & (r_level != '0);
  assign w_push_acc   = push & ~flush & (~is_full | w_pop_acc);
  assign w_next       = flush ? '0 : r_level + CW'(w_push_acc) - CW'(w_pop_acc);
  assign is_full      = r_level == CW'(DEPTH);
  assign is_empty     = r_level == '0;
  assign almost_full  = r_level >= af_thresh;
  assign almost_empty = r_level <= ae_thresh;
  assign level        = r_level;
  assign max_level    = r_max;
  assign overflow     = r_ovf;
  assign underflow    = r_unf;
  always_ff @(posedge clk)
    if (w_push_acc) r_mem[r_wr_ptr] <= data_in;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_max    <= '0;
      r_ovf    <= 1'b0;
      r_unf    <= 1'b0;
    end else begin
      r_level  <= w_next;
      r_max    <= (max_clr || w_next > r_max) ? w_next : r_max;
      r_ovf    <= push & ~flush & ~w_push_acc;
      r_unf    <= pop & ~flush & is_empty;
      r_wr_ptr <= flush ? '0 : r_wr_ptr + AW'(w_push_acc);
      r_rd_ptr <= flush ? '0 : r_rd_ptr + AW'(w_pop_acc);
    end
  end
  if (FWFT != 0) begin : g_fwft
    assign data_out = is_empty ? '0 : r_mem[r_rd_ptr];
  end else begin : g_reg
    logic [WIDTH-1:0] r_dout;
    always_ff @(posedge clk)
      if (rst) r_dout <= '0;
      else if (w_pop_acc) r_dout <= r_mem[r_rd_ptr];
    assign data_out = r_dout;
  end
endmodule
